// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_unit
// Brief    : Registered valid/ready initiator for the single-cycle ALU.
//            Decodes alu_op/funct3/funct7b5 to ALU sel, issues from S1,
//            captures the ALU output into an S2 response register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_unit #(
    parameter int WIDTH = 32,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_alu_op,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [ERRW-1:0]  err_count
);

    localparam logic [2:0] c_sel_add = 3'b000;
    localparam logic [2:0] c_sel_sub = 3'b001;
    localparam logic [2:0] c_sel_and = 3'b010;
    localparam logic [2:0] c_sel_or  = 3'b011;
    localparam logic [2:0] c_sel_slt = 3'b101;

    localparam logic [1:0] c_op_mem    = 2'b00;
    localparam logic [1:0] c_op_branch = 2'b01;
    localparam logic [1:0] c_op_rtype  = 2'b10;

    // S1 issue register
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_sel;
    logic             r_s1_illegal;

    // S2 response register
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_illegal;
    logic [ERRW-1:0]  r_err_count;

    logic [2:0]       w_sel;
    logic             w_illegal;
    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_req_ready;
    logic             w_accept;

    always_comb begin
        w_sel     = c_sel_add;
        w_illegal = 1'b0;
        case (req_alu_op)
            c_op_mem:    w_sel = c_sel_add;
            c_op_branch: w_sel = c_sel_sub;
            default: begin
                case (req_funct3)
                    // Only R-type uses bit 30 to select subtract.
                    3'b000: w_sel = (req_alu_op == c_op_rtype && req_funct7b5) ? c_sel_sub : c_sel_add;
                    3'b010: w_sel = c_sel_slt;
                    3'b110: w_sel = c_sel_or;
                    3'b111: w_sel = c_sel_and;
                    default: begin
                        w_sel     = c_sel_add;
                        w_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign w_s2_free   = !r_rsp_valid || rsp_ready;
    assign w_s1_adv    = r_s1_valid && w_s2_free;
    assign w_req_ready = !r_s1_valid || w_s1_adv;
    assign w_accept    = req_valid && w_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_sel     <= c_sel_add;
            r_s1_illegal <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            r_s1_a       <= req_a;
            r_s1_b       <= req_b;
            r_s1_sel     <= w_sel;
            r_s1_illegal <= w_illegal;
        end else if (w_s1_adv) begin
            r_s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else if (w_s1_adv) begin
            // Illegal ops still pass through the ALU; its output is dropped here.
            r_rsp_valid   <= 1'b1;
            r_rsp_result  <= r_s1_illegal ? '0 : alu_result;
            r_rsp_zero    <= r_s1_illegal ? 1'b0 : alu_zero;
            r_rsp_illegal <= r_s1_illegal;
        end else if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_accept && w_illegal && (r_err_count != {ERRW{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign req_ready   = w_req_ready;
    assign alu_a       = r_s1_a;
    assign alu_b       = r_s1_b;
    assign alu_sel     = r_s1_sel;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_illegal = r_rsp_illegal;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_unit
// Brief    : Scoreboard bench for alu_issue_unit with an attached ALU model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_issue_unit;

    localparam int WIDTH = 32;
    localparam int ERRW  = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_alu_op = '0;
    logic [2:0]       req_funct3 = '0;
    logic             req_funct7b5 = 1'b0;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_illegal;
    logic [ERRW-1:0]  err_count;

    alu_issue_unit #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Single-cycle ALU: 000 add, 001 sub, 010 and, 011 or, 101 unsigned slt.
    always_comb begin
        case (alu_sel)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   n_ill   = 0;
    int   n_push  = 0;
    int   n_pop   = 0;

    // Reference: name the operation, then compute its result arithmetically.
    task automatic model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [2:0] sel, output exp_t e);
        string kind;
        if (op == 2'd0)      kind = "add";
        else if (op == 2'd1) kind = "sub";
        else if (f3 == 3'd0) kind = (op == 2'd2 && f7) ? "sub" : "add";
        else if (f3 == 3'd2) kind = "slt";
        else if (f3 == 3'd6) kind = "or";
        else if (f3 == 3'd7) kind = "and";
        else                 kind = "ill";
        e.ill = 1'b0;
        case (kind)
            "add": begin sel = 3'd0; e.res = a + b; end
            "sub": begin sel = 3'd1; e.res = a - b; end
            "and": begin sel = 3'd2; e.res = a & b; end
            "or":  begin sel = 3'd3; e.res = a | b; end
            "slt": begin sel = 3'd5; e.res = {31'd0, a < b}; end
            default: begin sel = 3'd0; e.res = '0; e.ill = 1'b1; end
        endcase
        e.zero = !e.ill && (e.res == '0);
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int stalls);
        exp_t       e;
        logic [2:0] esel;
        model(op, f3, f7, a, b, esel, e);
        req_alu_op = op; req_funct3 = f3; req_funct7b5 = f7;
        req_a = a; req_b = b; req_valid = 1'b1;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            stalls++;
            if (stalls > 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout op=%0d f3=%0d req_ready stuck at 0, required 1", op, f3);
                req_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back(e);
        n_push++;
        if (e.ill) n_ill++;
        @(posedge clk); #1;
        checks++;
        if (alu_sel !== esel) begin
            errors++;
            $display("FAIL issue_sel op=%0d f3=%0d f7=%0d alu_sel=%b required %b", op, f3, f7, alu_sel, esel);
        end
        req_valid = 1'b0;
    endtask

    task automatic check1(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per handshaked response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid && rsp_ready) begin
                checks++;
                n_pop++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp result=%0h zero=%0b illegal=%0b required none",
                             rsp_result, rsp_zero, rsp_illegal);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_result !== e.res || rsp_zero !== e.zero || rsp_illegal !== e.ill) begin
                        errors++;
                        $display("FAIL rsp_payload result=%0h zero=%0b illegal=%0b required result=%0h zero=%0b illegal=%0b",
                                 rsp_result, rsp_zero, rsp_illegal, e.res, e.zero, e.ill);
                    end
                end
            end
        end
    end

    initial begin
        int st;
        int total_stalls;
        logic [2:0] f3s [5];
        f3s[0] = 3'd0; f3s[1] = 3'd2; f3s[2] = 3'd6; f3s[3] = 3'd7; f3s[4] = 3'd0;

        repeat (3) @(posedge clk);
        #1;
        check1("reset_req_ready", 32'(req_ready), 32'd1);
        check1("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check1("reset_alu_a",     alu_a, 32'd0);
        check1("reset_alu_sel",   32'(alu_sel), 32'd0);
        check1("reset_rsp_result", rsp_result, 32'd0);
        check1("reset_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single R-type add: response appears one edge after issue.
        rsp_ready = 1'b1;
        send(2'b10, 3'b000, 1'b0, 32'd5, 32'd7, st);
        check1("add_rsp_valid_n", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check1("add_rsp_valid_n1", 32'(rsp_valid), 32'd1);
        check1("add_rsp_result", rsp_result, 32'd12);

        // Branch-equal
        send(2'b01, 3'b000, 1'b0, 32'h1234, 32'h1234, st);
        repeat (2) @(posedge clk);
        #1;

        // Decode sweep with random operands
        for (int op = 0; op < 4; op++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int f7 = 0; f7 < 2; f7++)
                    send(op[1:0], f3[2:0], f7[0], $urandom, $urandom, st);
        repeat (3) @(posedge clk);
        #1;
        check1("err_count_sweep", 32'(err_count), 32'(n_ill));

        // Back-pressure: two fit, third stalls until rsp_ready returns.
        rsp_ready = 1'b0;
        send(2'b00, 3'b000, 1'b0, 32'd1, 32'd1, st);
        send(2'b00, 3'b000, 1'b0, 32'd2, 32'd1, st);
        req_a = 32'd3; req_alu_op = 2'b00; req_valid = 1'b1;
        @(negedge clk);
        check1("bp_req_ready_full", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check1("bp_rsp_hold", rsp_result, 32'd2);
        rsp_ready = 1'b1;
        fork
            begin
                send(2'b00, 3'b000, 1'b0, 32'd3, 32'd1, st);
                send(2'b00, 3'b000, 1'b0, 32'd4, 32'd1, st);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check1("bp_no_gap", 32'(rsp_valid), 32'd1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Full-rate random legal stream
        total_stalls = 0;
        for (int i = 0; i < 100; i++) begin
            send(2'($urandom_range(0, 3)), f3s[$urandom_range(0, 4)], 1'($urandom),
                 $urandom_range(0, 3) == 0 ? 32'd9 : $urandom, $urandom_range(0, 3) == 0 ? 32'd9 : $urandom, st);
            total_stalls += st;
        end
        check1("stream_stalls", 32'(total_stalls), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check1("stream_drained", 32'(exp_q.size()), 32'd0);
        check1("rsp_count", 32'(n_pop), 32'(n_push));

        // Reset with both stages full.
        rsp_ready = 1'b0;
        send(2'b00, 3'b000, 1'b0, 32'd10, 32'd1, st);
        send(2'b00, 3'b000, 1'b0, 32'd20, 32'd1, st);
        @(negedge clk);
        check1("full_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        check1("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q.delete();
        n_ill = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check1("post_reset_req_ready", 32'(req_ready), 32'd1);
        check1("post_reset_err_count", 32'(err_count), 32'd0);
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check1("post_reset_no_rsp", 32'(rsp_valid), 32'd0);

        // One illegal after reset restarts the count.
        send(2'b11, 3'b100, 1'b0, 32'd3, 32'd4, st);
        repeat (3) @(posedge clk);
        #1;
        check1("err_count_final", 32'(err_count), 32'd1);
        check1("final_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
